store_buffer: RTL and testbench

Write-posting store buffer between the execute stage's load/store/fence request port and the single-ported data memory bus. Stores complete to the pipeline in the cycle they are presented if an entry is free, then drain to memory in order in the background. Loads bypass pending stores unless they hit a buffered word. Fences stall until the buffer is empty. The execute stage holds its request stable while `mem_ready`=0 and stalls on it.

---
 rtl/store_buffer.sv | 176 +++++++++++++++++
 tb/tb_store_buffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write-posting store buffer with in-order drain; optional load forwarding under STOREBUFFER_FORWARD_EN
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_store,
    input  logic        mem_fence,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        dmem_valid,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [29:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [3:0]    buf_strb [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [1:0]    state;

    logic        full;
    logic        empty;
    logic        is_load;
    logic        enq;
    logic        deq;
    logic        hazard;
    logic        issue_load;
    logic [29:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_strb;
    logic        unused_addr_bits;
`ifdef STOREBUFFER_FORWARD_EN
    logic [31:0] fwd_data;
    logic [3:0]  fwd_strb;
`endif

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign is_load    = mem_valid && !mem_store && !mem_fence;
    assign enq        = mem_valid && mem_store && !full;
    assign deq        = (state == DRAIN) && dmem_ready;
    assign issue_load = is_load && !hazard && (state == IDLE);
    assign unused_addr_bits = ^mem_addr[1:0];

    // When the buffer is empty the store being accepted this cycle is the head, so it can issue at once
    assign drain_addr = empty ? mem_addr[31:2] : buf_addr[head];
    assign drain_data = empty ? mem_wdata      : buf_data[head];
    assign drain_strb = empty ? mem_wstrb      : buf_strb[head];

    // Walk entries oldest to youngest; the last match seen is the youngest buffered copy of the word
    always_comb begin
        hazard = 1'b0;
`ifdef STOREBUFFER_FORWARD_EN
        fwd_data = 32'h0;
        fwd_strb = 4'h0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (((PW+1)'(k) < count) && (buf_addr[head + PW'(k)] == mem_addr[31:2])) begin
                hazard = 1'b1;
`ifdef STOREBUFFER_FORWARD_EN
                fwd_data = buf_data[head + PW'(k)];
                fwd_strb = buf_strb[head + PW'(k)];
`endif
            end
        end
    end

    // Pipeline handshake: stores need a free slot, fences need a quiet buffer, loads finish on the bus
    always_comb begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        if (mem_valid) begin
            if (mem_store) begin
                mem_ready = !full;
            end else if (mem_fence) begin
                mem_ready = empty && (state == IDLE);
            end else if (state == LOAD) begin
                mem_ready = dmem_ready;
                if (dmem_ready) begin
                    mem_rdata = dmem_rdata;
                end
            end
`ifdef STOREBUFFER_FORWARD_EN
            else if (hazard && (fwd_strb == 4'hF)) begin
                mem_ready = 1'b1;
                mem_rdata = fwd_data;
            end
`endif
        end
    end

    // Entry storage written at the tail on every accepted store
    always_ff @(posedge clock) begin
        if (enq) begin
            buf_addr[tail] <= mem_addr[31:2];
            buf_data[tail] <= mem_wdata;
            buf_strb[tail] <= mem_wstrb;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous enqueue and dequeue leaves count unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus sequencer: one transaction at a time, loads win over drains when both are ready in IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            dmem_valid <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_wstrb <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_load) begin
                        state      <= LOAD;
                        dmem_valid <= 1'b1;
                        dmem_addr  <= {mem_addr[31:2], 2'b00};
                        dmem_wdata <= 32'h0;
                        dmem_wstrb <= 4'h0;
                    end else if (!empty || enq) begin
                        state      <= DRAIN;
                        dmem_valid <= 1'b1;
                        dmem_addr  <= {drain_addr, 2'b00};
                        dmem_wdata <= drain_data;
                        dmem_wstrb <= drain_strb;
                    end
                end
                LOAD, DRAIN: begin
                    if (dmem_ready) begin
                        state      <= IDLE;
                        dmem_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dmem_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and randomized checks of store_buffer against a program-order memory model
module tb_store_buffer;
    localparam int K_ST = 0;
    localparam int K_LD = 1;
    localparam int K_FN = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_store = 1'b0;
    logic        mem_fence = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    logic        mem_go = 1'b0;
    bit          rand_go = 1'b0;

    logic [31:0] phys [512];
    logic [31:0] arch [512];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;
    wr_t exp_wr [$];
    wr_t mon_w;

    int n_assert = 0;
    int n_fail = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] addr_prev = 32'h0;
    logic [31:0] last_dmem_addr;
    logic [3:0]  last_dmem_strb;
    logic [31:0] rd;
    int          lat;

    store_buffer #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_store(mem_store), .mem_fence(mem_fence),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clock = ~clock;

    assign dmem_ready = dmem_valid & mem_go;
    assign dmem_rdata = (dmem_valid && dmem_wstrb == 4'h0) ? phys[dmem_addr[10:2]] : 32'h0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A50000 ^ (32'(i) * 32'h01010101);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Bench memory: applies writes with strobes and checks they arrive in program order
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) phys[i] <= init_word(i);
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("dmem_valid_held", 32'(dmem_valid), 32'd1);
                check("dmem_addr_held", dmem_addr, addr_prev);
            end
            if (dmem_valid && dmem_ready && dmem_wstrb != 4'h0) begin
                check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    mon_w = exp_wr.pop_front();
                    check("write_addr", dmem_addr, mon_w.addr);
                    check("write_data", dmem_wdata, mon_w.data);
                    check("write_strb", 32'(dmem_wstrb), 32'(mon_w.strb));
                end
                phys[dmem_addr[10:2]] <= merge(phys[dmem_addr[10:2]], dmem_wdata, dmem_wstrb);
            end
            hold_prev <= dmem_valid && !dmem_ready;
            addr_prev <= dmem_addr;
        end
    end

    task automatic arch_reset();
        for (int i = 0; i < 512; i++) arch[i] = init_word(i);
        exp_wr.delete();
    endtask

    task automatic present(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid = 1'b1;
        mem_store = (kind == K_ST);
        mem_fence = (kind == K_FN);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
    endtask

    // Waits for mem_ready and settles the request against the program-order model
    task automatic finish_req(input int budget, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clock);
            if (mem_ready) break;
            cycles++;
            if (cycles > budget) break;
            @(posedge clock);
            #1;
            if (rand_go) mem_go = ($urandom_range(0, 3) != 0);
        end
        n_assert++;
        assert (cycles <= budget) else begin
            n_fail++;
            $error("FAIL request_timeout: observed %0d cycles expected at most %0d", cycles, budget);
        end
        last_dmem_addr = dmem_addr;
        last_dmem_strb = dmem_wstrb;
        if (cycles <= budget) begin
            if (mem_store) begin
                arch[mem_addr[10:2]] = merge(arch[mem_addr[10:2]], mem_wdata, mem_wstrb);
                exp_wr.push_back('{addr: {mem_addr[31:2], 2'b00}, data: mem_wdata, strb: mem_wstrb});
                check("store_rdata_zero", mem_rdata, 32'h0);
            end else if (mem_fence) begin
                check("fence_rdata_zero", mem_rdata, 32'h0);
            end else begin
                check("load_data", mem_rdata, arch[mem_addr[10:2]]);
            end
        end
        @(posedge clock);
        #1;
        mem_valid = 1'b0;
        mem_store = 1'b0;
        mem_fence = 1'b0;
        if (rand_go) mem_go = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_req(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int cycles);
        present(kind, a, d, s);
        finish_req(200, cycles);
    endtask

    task automatic not_ready(input string tag);
        @(negedge clock);
        check(tag, 32'(mem_ready), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        arch_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_dmem_valid", 32'(dmem_valid), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_dmem_wdata", dmem_wdata, 32'h0);
        check("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mem_go = 1'b1;

        // Store to an empty buffer completes at once and issues the next cycle
        do_req(K_ST, 32'h100, 32'hDEADBEEF, 4'hF, lat);
        check("store_latency", 32'(lat), 32'd0);
        @(negedge clock);
        check("store_issue_valid", 32'(dmem_valid), 32'd1);
        check("store_issue_addr", dmem_addr, 32'h100);
        check("store_issue_strb", 32'(dmem_wstrb), 32'hF);
        check("store_issue_data", dmem_wdata, 32'hDEADBEEF);
        check("idle_ready_low", 32'(mem_ready), 32'd0);
        check("idle_rdata_zero", mem_rdata, 32'h0);
        @(posedge clock);
        #1;

        // Fill with memory stalled; the fifth store waits for the first dequeue and wraps
        mem_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_req(K_ST, 32'(i * 4), $urandom, 4'hF, lat);
            check("fill_latency", 32'(lat), 32'd0);
        end
        present(K_ST, 32'h10, 32'h0BADF00D, 4'hF);
        repeat (3) not_ready("full_store_waits");
        mem_go = 1'b1;
        finish_req(200, lat);
        check("full_store_latency", 32'(lat), 32'd1);
        do_req(K_FN, 32'h0, 32'h0, 4'h0, lat);

        // Load to an unbuffered word overtakes a pending store
        mem_go = 1'b0;
        do_req(K_ST, 32'h180, 32'h11112222, 4'hF, lat);
        do_req(K_ST, 32'h200, 32'hAAAA5555, 4'hF, lat);
        present(K_LD, 32'h300, 32'h0, 4'h0);
        not_ready("bypass_load_waits_drain");
        mem_go = 1'b1;
        finish_req(200, lat);
        check("bypass_load_latency", 32'(lat), 32'd2);
        check("bypass_load_is_read", 32'(last_dmem_strb), 32'd0);
        check("bypass_load_addr", last_dmem_addr, 32'h300);
        do_req(K_FN, 32'h0, 32'h0, 4'h0, lat);

        // Load hitting a full-strobe buffered word
        mem_go = 1'b0;
        do_req(K_ST, 32'h180, 32'h33334444, 4'hF, lat);
        do_req(K_ST, 32'h200, 32'h12345678, 4'hF, lat);
        present(K_LD, 32'h202, 32'h0, 4'h0);
`ifdef STOREBUFFER_FORWARD_EN
        finish_req(4, lat);
        check("forward_latency", 32'(lat), 32'd0);
        mem_go = 1'b1;
`else
        not_ready("hazard_load_waits");
        mem_go = 1'b1;
        finish_req(200, lat);
        check("hazard_load_latency", 32'(lat), 32'd4);
`endif
        do_req(K_FN, 32'h0, 32'h0, 4'h0, lat);

        // Partial-strobe hazard always waits for the drain
        mem_go = 1'b0;
        do_req(K_ST, 32'h240, 32'hCAFEF00D, 4'h3, lat);
        present(K_LD, 32'h240, 32'h0, 4'h0);
        repeat (2) not_ready("partial_hazard_waits");
        mem_go = 1'b1;
        finish_req(200, lat);
        check("partial_hazard_latency", 32'(lat), 32'd2);

        // Fence with three stores, head already in flight when memory is released
        mem_go = 1'b0;
        for (int i = 0; i < 3; i++) do_req(K_ST, 32'h20 + 32'(i * 4), $urandom, 4'hF, lat);
        present(K_FN, 32'h0, 32'h0, 4'h0);
        not_ready("fence_waits");
        mem_go = 1'b1;
        finish_req(200, lat);
        check("fence_latency_stalled", 32'(lat), 32'd5);

        // Back-to-back stores with zero-wait memory then a fence
        for (int i = 0; i < 3; i++) do_req(K_ST, 32'h60 + 32'(i * 4), $urandom, 4'hF, lat);
        do_req(K_FN, 32'h0, 32'h0, 4'h0, lat);
        check("fence_latency_streamed", 32'(lat), 32'd3);

        // Reset during a drain discards the buffer and clears the bus
        mem_go = 1'b0;
        do_req(K_ST, 32'h300, 32'h76543210, 4'hF, lat);
        @(negedge clock);
        check("drain_in_flight", 32'(dmem_valid), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        arch_reset();
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
        check("mid_rst_mem_rdata", mem_rdata, 32'h0);
        check("mid_rst_dmem_valid", 32'(dmem_valid), 32'd0);
        check("mid_rst_dmem_addr", dmem_addr, 32'h0);
        check("mid_rst_dmem_wdata", dmem_wdata, 32'h0);
        check("mid_rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mem_go = 1'b1;
        do_req(K_LD, 32'h44, 32'h0, 4'h0, lat);
        check("post_reset_load_latency", 32'(lat), 32'd1);

        // Random traffic over a small window of words with a random memory stall pattern
        rand_go = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = 32'h400 + 32'($urandom_range(0, 7) * 4);
            if (r < 5) do_req(K_ST, a, $urandom, 4'($urandom_range(1, 15)), lat);
            else if (r < 9) do_req(K_LD, a + 32'($urandom_range(0, 3)), 32'h0, 4'h0, lat);
            else do_req(K_FN, 32'h0, 32'h0, 4'h0, lat);
        end
        rand_go = 1'b0;
        mem_go = 1'b1;
        do_req(K_FN, 32'h0, 32'h0, 4'h0, lat);
        @(negedge clock);
        for (int i = 0; i < 8; i++) check("final_memory", phys[9'h100 + 9'(i)], arch[9'h100 + 9'(i)]);
        check("writes_all_drained", 32'(exp_wr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
